// File: rtl/nrzi_toggle_decoder_pkg.sv
// nrzi_pkg: shared FSM state type and default framing constants
// for the toggle-encoded line receiver.
package nrzi_pkg;

  typedef enum logic {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_SYNC_W = 8;
  localparam logic [7:0] DEF_SYNC = 8'hD5;
  localparam int DEF_FRAME_WORDS = 4;
  localparam int DEF_STUFF_RUN = 6;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nrzi_toggle_decoder_if.sv
// Line-side and word-side signals of the toggle-line receiver.
// master = sampler/consumer side, slave = decoder side.
interface nrzi_toggle_decoder_if #(
  parameter int DATA_W = 8
);

  logic              line_in;
  logic              sample_en;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              sync_found;
  logic              overrun;
  logic              stuff_err;

  modport master (
    output line_in,
    output sample_en,
    output out_ready,
    input  out_data,
    input  out_valid,
    input  sync_found,
    input  overrun,
    input  stuff_err
  );

  modport slave (
    input  line_in,
    input  sample_en,
    input  out_ready,
    output out_data,
    output out_valid,
    output sync_found,
    output overrun,
    output stuff_err
  );

endinterface

// File: rtl/nrzi_toggle_decoder_bit_decode.sv
// toggle_bit_decode: recovers one bit per sample strobe as
// the XOR of the current and previous line levels.
module toggle_bit_decode (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  input  logic sample_en,
  output logic dbit,
  output logic dbit_vld
);

  logic line_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_prev <= 1'b0;
    end else if (sample_en) begin
      line_prev <= line_in;
    end
  end

  assign dbit     = sample_en & (line_in ^ line_prev);
  assign dbit_vld = sample_en;

endmodule

// File: rtl/nrzi_toggle_decoder.sv
// Toggle-line receiver: sync hunt, word assembly, holding register.
// Optional destuffing when NRZI_DESTUFF_EN is defined.
module nrzi_toggle_decoder
  import nrzi_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_W      = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_W'(DEF_SYNC),
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int STUFF_RUN   = DEF_STUFF_RUN
) (
  input logic clk,
  input logic rst,
  nrzi_toggle_decoder_if.slave bus
);

  localparam int BCW = cw(DATA_W);
  localparam int WCW = cw(FRAME_WORDS + 1);

  if (STUFF_RUN < 1) begin : g_bad_run
    $error("STUFF_RUN must be at least 1");
  end

  logic dbit;
  logic dbit_vld;

  toggle_bit_decode u_dec (
    .clk       (clk),
    .rst       (rst),
    .line_in   (bus.line_in),
    .sample_en (bus.sample_en),
    .dbit      (dbit),
    .dbit_vld  (dbit_vld)
  );

  state_t state_q, state_d;
  logic [SYNC_W-1:0] hunt_q, hunt_d, hunt_nx;
  logic [DATA_W-1:0] data_q, data_d, word_nx;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [DATA_W-1:0] odata_q, odata_d;
  logic ovld_q, ovld_d;
  logic sync_q, sync_d;
  logic ovr_q, ovr_d;
  logic word_done;
  logic stuff_hit;

  assign hunt_nx = {dbit, hunt_q[SYNC_W-1:1]};
  assign word_nx = {dbit, data_q[DATA_W-1:1]};

`ifdef NRZI_DESTUFF_EN
  localparam int RCW = cw(STUFF_RUN + 1);
  logic [RCW-1:0] run_q, run_d;
  logic serr_q, serr_d;

  assign stuff_hit = (state_q == SHIFT) &&
                     (run_q == RCW'(STUFF_RUN));

  // run of 1s only counts decoded data bits inside a frame
  always_comb begin
    run_d = run_q;
    if (dbit_vld) begin
      if (state_q == HUNT || stuff_hit || !dbit) begin
        run_d = '0;
      end else begin
        run_d = run_q + RCW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q  <= '0;
      serr_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      serr_q <= serr_d;
    end
  end

  assign bus.stuff_err = serr_q;
`else
  assign stuff_hit     = 1'b0;
  assign bus.stuff_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    hunt_d    = hunt_q;
    data_d    = data_q;
    bcnt_d    = bcnt_q;
    wcnt_d    = wcnt_q;
    sync_d    = 1'b0;
    word_done = 1'b0;
`ifdef NRZI_DESTUFF_EN
    serr_d    = 1'b0;
`endif
    if (dbit_vld) begin
      unique case (state_q)
        HUNT: begin
          hunt_d = hunt_nx;
          if (hunt_nx == SYNC_PATTERN) begin
            state_d = SHIFT;
            sync_d  = 1'b1;
            bcnt_d  = '0;
            wcnt_d  = '0;
          end
        end
        SHIFT: begin
          if (stuff_hit) begin
            // stuff bit is dropped; a 1 here means the line is broken
            if (dbit) begin
`ifdef NRZI_DESTUFF_EN
              serr_d  = 1'b1;
`endif
              state_d = HUNT;
              hunt_d  = '0;
              data_d  = '0;
              bcnt_d  = '0;
            end
          end else begin
            data_d = word_nx;
            bcnt_d = bcnt_q + BCW'(1);
            if (bcnt_q == BCW'(DATA_W - 1)) begin
              word_done = 1'b1;
              bcnt_d    = '0;
              wcnt_d    = wcnt_q + WCW'(1);
              if (wcnt_q == WCW'(FRAME_WORDS - 1)) begin
                state_d = HUNT;
                hunt_d  = '0;
              end
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // single-entry holding register; a same-cycle handshake frees it
  always_comb begin
    odata_d = odata_q;
    ovld_d  = ovld_q;
    ovr_d   = 1'b0;
    if (word_done) begin
      if (!ovld_q || bus.out_ready) begin
        odata_d = word_nx;
        ovld_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (ovld_q && bus.out_ready) begin
      ovld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      hunt_q  <= '0;
      data_q  <= '0;
      bcnt_q  <= '0;
      wcnt_q  <= '0;
      odata_q <= '0;
      ovld_q  <= 1'b0;
      sync_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hunt_q  <= hunt_d;
      data_q  <= data_d;
      bcnt_q  <= bcnt_d;
      wcnt_q  <= wcnt_d;
      odata_q <= odata_d;
      ovld_q  <= ovld_d;
      sync_q  <= sync_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.out_data   = odata_q;
  assign bus.out_valid  = ovld_q;
  assign bus.sync_found = sync_q;
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_nrzi_toggle_decoder.sv
// Directed bench for nrzi_toggle_decoder; destuff cases run
// only when NRZI_DESTUFF_EN is defined.
module tb_nrzi_toggle_decoder;

  logic clk;
  logic rst;

  nrzi_toggle_decoder_if #(.DATA_W(8)) bus ();

  nrzi_toggle_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int sync_cnt = 0;
  int ovr_cnt = 0;
  int serr_cnt = 0;
  logic [7:0] got[$];
  logic lv = 1'b0;
  int run = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.sync_found) sync_cnt++;
      if (bus.overrun) ovr_cnt++;
      if (bus.stuff_err) serr_cnt++;
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input int i);
    return (got.size() > i) ? 32'(got[i]) : 32'hDEAD;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.line_in = 1'b0;
    bus.sample_en = 1'b0;
    bus.out_ready = 1'b0;
    lv = 1'b0;
    run = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sync_cnt = 0;
    ovr_cnt = 0;
    serr_cnt = 0;
    got.delete();
  endtask

  task automatic send_bit(input logic b, input int gap);
    lv = lv ^ b;
    bus.line_in = lv;
    bus.sample_en = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_en = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_raw(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit(w[i], 3);
    run = 0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      send_bit(w[i], 3);
`ifdef NRZI_DESTUFF_EN
      run = w[i] ? run + 1 : 0;
      if (run == 6) begin
        send_bit(1'b0, 3);
        run = 0;
      end
`endif
    end
  endtask

  initial begin
    logic [7:0] w;
    do_reset();
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_data", 32'(bus.out_data), 0);
    chk("rst_sync", 32'(bus.sync_found), 0);
    chk("rst_ovr", 32'(bus.overrun), 0);
    chk("rst_serr", 32'(bus.stuff_err), 0);

    // constant line: every decoded bit is 0
    for (int i = 0; i < 64; i++) send_bit(1'b0, 3);
    chk("idle_sync", 32'(sync_cnt), 0);
    chk("idle_valid", 32'(bus.out_valid), 0);
    chk("idle_words", 32'(got.size()), 0);

    // full frame with consumer always ready
    bus.out_ready = 1'b1;
    send_raw(8'hD5);
    w = 8'h3C;
    for (int i = 0; i < 7; i++) send_bit(w[i], 3);
    chk("lat_before", 32'(bus.out_valid), 0);
    send_bit(w[7], 0);
    chk("lat_valid", 32'(bus.out_valid), 1);
    chk("lat_data", 32'(bus.out_data), 32'h3C);
    repeat (3) @(posedge clk);
    #1;
    send_word(8'hA5);
    send_word(8'h00);
    send_word(8'hFF);
    send_word(8'h5A);
    repeat (4) @(posedge clk);
    #1;
    chk("frm_sync", 32'(sync_cnt), 1);
    chk("frm_nwords", 32'(got.size()), 4);
    chk("frm_w0", q_at(0), 32'h3C);
    chk("frm_w1", q_at(1), 32'hA5);
    chk("frm_w2", q_at(2), 32'h00);
    chk("frm_w3", q_at(3), 32'hFF);
    chk("frm_hunt_valid", 32'(bus.out_valid), 0);

    // consumer stalled: later words dropped with overrun
    do_reset();
    send_raw(8'hD5);
    send_word(8'h3C);
    send_word(8'hA5);
    send_word(8'h00);
    send_word(8'hFF);
    chk("ovr_valid", 32'(bus.out_valid), 1);
    chk("ovr_data", 32'(bus.out_data), 32'h3C);
    chk("ovr_count", 32'(ovr_cnt), 3);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ovr_drain", 32'(bus.out_valid), 0);

    // completion coincides with handshake of previous word
    do_reset();
    send_raw(8'hD5);
    send_word(8'h3C);
    w = 8'h81;
    for (int i = 0; i < 7; i++) send_bit(w[i], 3);
    bus.out_ready = 1'b1;
    send_bit(w[7], 0);
    bus.out_ready = 1'b0;
    chk("same_valid", 32'(bus.out_valid), 1);
    chk("same_data", 32'(bus.out_data), 32'h81);
    repeat (2) @(posedge clk);
    #1;
    chk("same_ovr", 32'(ovr_cnt), 0);

    // asynchronous reset mid-frame
    do_reset();
    send_raw(8'hD5);
    send_word(8'h3C);
    send_bit(1'b1, 1);
    send_bit(1'b0, 1);
    send_bit(1'b1, 1);
    chk("mid_pending", 32'(bus.out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_valid", 32'(bus.out_valid), 0);
    chk("mid_data", 32'(bus.out_data), 0);
    do_reset();
    bus.out_ready = 1'b1;
    send_raw(8'hD5);
    send_word(8'h11);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_resend_n", 32'(got.size()), 1);
    chk("mid_resend", q_at(0), 32'h11);

`ifdef NRZI_DESTUFF_EN
    do_reset();
    bus.out_ready = 1'b1;
    send_raw(8'hD5);
    for (int i = 0; i < 6; i++) send_bit(1'b1, 3);
    send_bit(1'b0, 3);
    send_bit(1'b1, 3);
    send_bit(1'b1, 3);
    repeat (2) @(posedge clk);
    #1;
    chk("ds_word", q_at(0), 32'hFF);
    chk("ds_nerr", 32'(serr_cnt), 0);

    do_reset();
    bus.out_ready = 1'b1;
    send_raw(8'hD5);
    for (int i = 0; i < 7; i++) send_bit(1'b1, 3);
    chk("ds_err", 32'(serr_cnt), 1);
    chk("ds_noword", 32'(got.size()), 0);
    send_raw(8'hD5);
    send_word(8'h42);
    repeat (2) @(posedge clk);
    #1;
    chk("ds_resync", 32'(sync_cnt), 2);
    chk("ds_after", q_at(0), 32'h42);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
